exc_collector: RTL and testbench
================================

Name: exc_collector

Overview:
- Pipeline-side producer of the unified exception bus that CP0 consumes in WB.
- Tags each in-flight instruction with the first exception it raises in IF/ID/EXE/MEM and carries the tag with the instruction to WB.
- Drives ex_valid/ex_code/ex_bd/ex_pc/badvaddr to CP0 and flushes all carried tags when CP0 asserts cancel.
- Tells MEM to suppress side effects for tagged instructions.

Parameters:
- PC_W, 32, width of PC and bad virtual address.

Ports:
- clk  in  1  clock.
- resetn  in  1  synchronous reset, active low.
- ifid_go  in  1  instruction moves IF->ID this cycle.
- idexe_go  in  1  ID->EXE transfer.
- exemem_go  in  1  EXE->MEM transfer.
- memwb_go  in  1  MEM->WB transfer.
- wb_over  in  1  WB instruction retires this cycle.
- cancel  in  1  flush from CP0.
- if_pc  in  PC_W  PC of the instruction leaving IF.
- if_adel  in  1  fetch address error.
- id_bd  in  1  ID instruction is in a delay slot.
- id_ri  in  1  reserved instruction.
- id_sys  in  1  SYSCALL.
- id_brk  in  1  BREAK.
- exe_ov  in  1  arithmetic overflow.
- mem_adel  in  1  load address error.
- mem_ades  in  1  store address error.
- mem_addr  in  PC_W  data address in MEM.
- c0_int  in  1  interrupt request from CP0.
- ex_valid_o  out  1  WB instruction carries an exception.
- ex_code_o  out  5  ExcCode.
- ex_bd_o  out  1  delay-slot flag.
- ex_pc_o  out  PC_W  EPC value.
- badvaddr_valid_o  out  1  badvaddr_o meaningful.
- badvaddr_o  out  PC_W  faulting address.
- mem_kill_o  out  1  MEM-stage memory write/request must be suppressed.

Behaviour:
- Four tag registers: ID, EXE, MEM, WB. Each holds {v, code[4:0], bd, pc, bv, bva}.
- Reset and cancel: every field of every tag register is 0. Reset values of all outputs are 0.
- Cancel has priority over every go input in the same cycle. All tags clear and nothing loads that cycle.
- Loading a stage (X_go asserted into stage S): S <= upstream tag merged with the exceptions raised by the source stage. An existing upstream v=1 is never overwritten, so the earliest stage wins.
- Into ID: tag comes only from IF. if_adel gives code 0x04, bv=1, bva=if_pc. pc=if_pc for every instruction; bd=0.
- Into EXE: bd <= id_bd (always, tagged or not). If no tag yet, priority is id_ri 0x0a > id_sys 0x08 > id_brk 0x09.
- Into MEM: if no tag and exe_ov, code 0x0c.
- Into WB: if no tag, mem_adel gives 0x04 and mem_ades gives 0x05 (adel wins if both). Either sets bv=1, bva=mem_addr.
- Bubble: when a stage's outgoing go is 1 and its incoming go is 0, that stage's tag clears. When neither go is asserted, the tag holds.
- WB tag clears on wb_over unless memwb_go is asserted in the same cycle.
- Outputs are combinational from the WB tag register:
  - ex_valid_o = WB.v.
  - ex_code_o = WB.code.
  - ex_bd_o = WB.bd.
  - ex_pc_o = WB.bd ? WB.pc - 4 : WB.pc, computed modulo 2^PC_W.
  - badvaddr_valid_o = WB.v & WB.bv.
  - All outputs are 0 when WB.v = 0.
- mem_kill_o = MEM.v | mem_adel | mem_ades | WB.v. An exception in WB squashes the younger instruction in MEM.
- Simultaneous new exceptions in two stages: each attaches to its own instruction. No cross-instruction priority is needed because CP0 takes only WB.

Optional Feature:
- Macro EXC_INT_TAG_EN.
- Defined: c0_int is sampled when memwb_go loads WB. If c0_int=1, the incoming tag is replaced by code 0x00, bv=0, while pc and bd are kept. Interrupt priority is above all synchronous exceptions.
- Undefined: c0_int is ignored, and CP0 handles interrupts independently.

Test Plan:
- Reset low for 2 cycles, then advance a clean instruction pc=0x100 to WB -> all outputs 0 throughout; mem_kill_o=0.
- if_adel with if_pc=0x0000_0102, advanced to WB -> ex_valid_o=1, code=0x04, ex_pc_o=0x102, badvaddr_o=0x102, badvaddr_valid_o=1.
- id_bd=1 plus id_sys, pc=0x204 -> at WB code=0x08, ex_bd_o=1, ex_pc_o=0x200, badvaddr_valid_o=0.
- Instruction already tagged RI in ID that also asserts exe_ov and mem_ades -> WB code stays 0x0a; mem_kill_o=1 while it is in MEM.
- Tagged instruction in MEM with cancel and memwb_go asserted in the same cycle -> next cycle all tags 0, ex_valid_o=0, and the instruction never appears in WB.
- Stall: tag in EXE held 5 cycles with all go=0 -> tag retained; then one exemem_go with idexe_go=0 -> MEM holds the tag and EXE is empty.

Source files
------------

// File: rtl/exc_collector.sv
// Exception tag pipeline: records the first exception each instruction raises in IF/ID/EXE/MEM
// and presents it to CP0 from WB. Optional build macro EXC_INT_TAG_EN tags interrupts on entry to WB.
module exc_collector #(
    parameter int PC_W = 32
) (
    input  logic            clk,
    input  logic            resetn,
    input  logic            ifid_go,
    input  logic            idexe_go,
    input  logic            exemem_go,
    input  logic            memwb_go,
    input  logic            wb_over,
    input  logic            cancel,
    input  logic [PC_W-1:0] if_pc,
    input  logic            if_adel,
    input  logic            id_bd,
    input  logic            id_ri,
    input  logic            id_sys,
    input  logic            id_brk,
    input  logic            exe_ov,
    input  logic            mem_adel,
    input  logic            mem_ades,
    input  logic [PC_W-1:0] mem_addr,
    input  logic            c0_int,
    output logic            ex_valid_o,
    output logic [4:0]      ex_code_o,
    output logic            ex_bd_o,
    output logic [PC_W-1:0] ex_pc_o,
    output logic            badvaddr_valid_o,
    output logic [PC_W-1:0] badvaddr_o,
    output logic            mem_kill_o
);

    localparam logic [4:0] EXC_INT  = 5'h00;
    localparam logic [4:0] EXC_ADEL = 5'h04;
    localparam logic [4:0] EXC_ADES = 5'h05;
    localparam logic [4:0] EXC_SYS  = 5'h08;
    localparam logic [4:0] EXC_BP   = 5'h09;
    localparam logic [4:0] EXC_RI   = 5'h0a;
    localparam logic [4:0] EXC_OV   = 5'h0c;

    typedef struct packed {
        logic            v;
        logic [4:0]      code;
        logic            bd;
        logic [PC_W-1:0] pc;
        logic            bv;
        logic [PC_W-1:0] bva;
    } tag_t;

    tag_t id_q, exe_q, mem_q, wb_q;
    tag_t id_d, exe_d, mem_d, wb_d;
    tag_t id_load, exe_load, mem_load, wb_load;

    // Candidate tag for each stage if its incoming go fires; an existing tag is never replaced.
    always_comb begin
        id_load    = '0;
        id_load.pc = if_pc;
        if (if_adel) begin
            id_load.v    = 1'b1;
            id_load.code = EXC_ADEL;
            id_load.bv   = 1'b1;
            id_load.bva  = if_pc;
        end

        exe_load    = id_q;
        exe_load.bd = id_bd;
        if (!id_q.v) begin
            if (id_ri) begin
                exe_load.v    = 1'b1;
                exe_load.code = EXC_RI;
            end else if (id_sys) begin
                exe_load.v    = 1'b1;
                exe_load.code = EXC_SYS;
            end else if (id_brk) begin
                exe_load.v    = 1'b1;
                exe_load.code = EXC_BP;
            end
        end

        mem_load = exe_q;
        if (!exe_q.v && exe_ov) begin
            mem_load.v    = 1'b1;
            mem_load.code = EXC_OV;
        end

        wb_load = mem_q;
        if (!mem_q.v) begin
            if (mem_adel) begin
                wb_load.v    = 1'b1;
                wb_load.code = EXC_ADEL;
                wb_load.bv   = 1'b1;
                wb_load.bva  = mem_addr;
            end else if (mem_ades) begin
                wb_load.v    = 1'b1;
                wb_load.code = EXC_ADES;
                wb_load.bv   = 1'b1;
                wb_load.bva  = mem_addr;
            end
        end
`ifdef EXC_INT_TAG_EN
        // Interrupt outranks any synchronous exception but keeps the instruction's pc/bd for EPC.
        if (c0_int) begin
            wb_load.v    = 1'b1;
            wb_load.code = EXC_INT;
            wb_load.bv   = 1'b0;
            wb_load.bva  = '0;
        end
`endif
    end

`ifndef EXC_INT_TAG_EN
    logic unused_c0_int;
    assign unused_c0_int = c0_int;
`endif

    // A stage empties when its instruction leaves and nothing arrives behind it.
    always_comb begin
        id_d  = id_q;
        exe_d = exe_q;
        mem_d = mem_q;
        wb_d  = wb_q;

        if (ifid_go)        id_d = id_load;
        else if (idexe_go)  id_d = '0;

        if (idexe_go)       exe_d = exe_load;
        else if (exemem_go) exe_d = '0;

        if (exemem_go)      mem_d = mem_load;
        else if (memwb_go)  mem_d = '0;

        if (memwb_go)       wb_d = wb_load;
        else if (wb_over)   wb_d = '0;
    end

    always_ff @(posedge clk) begin
        if (!resetn || cancel) begin
            id_q  <= '0;
            exe_q <= '0;
            mem_q <= '0;
            wb_q  <= '0;
        end else begin
            id_q  <= id_d;
            exe_q <= exe_d;
            mem_q <= mem_d;
            wb_q  <= wb_d;
        end
    end

    assign ex_valid_o       = wb_q.v;
    assign ex_code_o        = wb_q.v ? wb_q.code : 5'h00;
    assign ex_bd_o          = wb_q.v & wb_q.bd;
    assign ex_pc_o          = !wb_q.v ? '0 : (wb_q.bd ? wb_q.pc - PC_W'(4) : wb_q.pc);
    assign badvaddr_valid_o = wb_q.v & wb_q.bv;
    assign badvaddr_o       = (wb_q.v & wb_q.bv) ? wb_q.bva : '0;

    // An exception already in WB also squashes the younger instruction behind it.
    assign mem_kill_o = mem_q.v | mem_adel | mem_ades | wb_q.v;

endmodule

// File: tb/tb_exc_collector.sv
// Self-checking bench for exc_collector: directed scenarios plus randomized pipeline traffic
// compared against an instruction-level reference model.
module tb_exc_collector;
    localparam int PC_W = 32;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic resetn, ifid_go, idexe_go, exemem_go, memwb_go, wb_over, cancel;
    logic [PC_W-1:0] if_pc, mem_addr;
    logic if_adel, id_bd, id_ri, id_sys, id_brk, exe_ov, mem_adel, mem_ades, c0_int;
    logic ex_valid_o, ex_bd_o, badvaddr_valid_o, mem_kill_o;
    logic [4:0] ex_code_o;
    logic [PC_W-1:0] ex_pc_o, badvaddr_o;

    exc_collector #(.PC_W(PC_W)) dut (
        .clk(clk), .resetn(resetn), .ifid_go(ifid_go), .idexe_go(idexe_go),
        .exemem_go(exemem_go), .memwb_go(memwb_go), .wb_over(wb_over), .cancel(cancel),
        .if_pc(if_pc), .if_adel(if_adel), .id_bd(id_bd), .id_ri(id_ri), .id_sys(id_sys),
        .id_brk(id_brk), .exe_ov(exe_ov), .mem_adel(mem_adel), .mem_ades(mem_ades),
        .mem_addr(mem_addr), .c0_int(c0_int), .ex_valid_o(ex_valid_o), .ex_code_o(ex_code_o),
        .ex_bd_o(ex_bd_o), .ex_pc_o(ex_pc_o), .badvaddr_valid_o(badvaddr_valid_o),
        .badvaddr_o(badvaddr_o), .mem_kill_o(mem_kill_o)
    );

    int checks = 0;
    int errors = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Reference model: one record per pipeline slot describing the instruction there.
    // code < 0 means the instruction has raised nothing so far.
    typedef struct {
        int          code;
        logic [31:0] pc;
        bit          bd;
        bit          bv;
        logic [31:0] bva;
    } slot_t;

    slot_t m_id, m_exe, m_mem, m_wb;

    function automatic slot_t empty_slot();
        slot_t s;
        s.code = -1; s.pc = '0; s.bd = 0; s.bv = 0; s.bva = '0;
        return s;
    endfunction

    // The first exception an instruction raises is the one it keeps.
    function automatic slot_t raise(slot_t s, int code, bit bv, logic [31:0] bva);
        slot_t r = s;
        if (r.code < 0) begin
            r.code = code; r.bv = bv; r.bva = bva;
        end
        return r;
    endfunction

    task automatic model_step();
        slot_t n_id, n_exe, n_mem, n_wb;
        n_id = m_id; n_exe = m_exe; n_mem = m_mem; n_wb = m_wb;
        if (!resetn || cancel) begin
            n_id = empty_slot(); n_exe = empty_slot(); n_mem = empty_slot(); n_wb = empty_slot();
        end else begin
            if (ifid_go) begin
                n_id = empty_slot();
                n_id.pc = if_pc;
                if (if_adel) n_id = raise(n_id, 4, 1, if_pc);
            end else if (idexe_go) n_id = empty_slot();

            if (idexe_go) begin
                n_exe = m_id;
                n_exe.bd = id_bd;
                if (id_ri)  n_exe = raise(n_exe, 10, 0, 0);
                if (id_sys) n_exe = raise(n_exe, 8, 0, 0);
                if (id_brk) n_exe = raise(n_exe, 9, 0, 0);
            end else if (exemem_go) n_exe = empty_slot();

            if (exemem_go) begin
                n_mem = m_exe;
                if (exe_ov) n_mem = raise(n_mem, 12, 0, 0);
            end else if (memwb_go) n_mem = empty_slot();

            if (memwb_go) begin
                n_wb = m_mem;
                if (mem_adel) n_wb = raise(n_wb, 4, 1, mem_addr);
                if (mem_ades) n_wb = raise(n_wb, 5, 1, mem_addr);
`ifdef EXC_INT_TAG_EN
                if (c0_int) begin
                    n_wb.code = 0; n_wb.bv = 0; n_wb.bva = '0;
                end
`endif
            end else if (wb_over) n_wb = empty_slot();
        end
        m_id = n_id; m_exe = n_exe; m_mem = n_mem; m_wb = n_wb;
    endtask

    task automatic check_outputs();
        bit v = (m_wb.code >= 0);
        check("ex_valid", ex_valid_o, v);
        check("ex_code", ex_code_o, v ? m_wb.code[4:0] : 5'h00);
        check("ex_bd", ex_bd_o, v & m_wb.bd);
        check("ex_pc", ex_pc_o, !v ? 32'h0 : (m_wb.bd ? m_wb.pc - 32'd4 : m_wb.pc));
        check("bv_valid", badvaddr_valid_o, v & m_wb.bv);
        check("badvaddr", badvaddr_o, (v && m_wb.bv) ? m_wb.bva : 32'h0);
        check("mem_kill", mem_kill_o, (m_mem.code >= 0) | mem_adel | mem_ades | v);
    endtask

    task automatic zero_inputs();
        ifid_go = 0; idexe_go = 0; exemem_go = 0; memwb_go = 0; wb_over = 0; cancel = 0;
        if_pc = '0; if_adel = 0; id_bd = 0; id_ri = 0; id_sys = 0; id_brk = 0;
        exe_ov = 0; mem_adel = 0; mem_ades = 0; mem_addr = '0; c0_int = 0;
    endtask

    // Inputs are driven just after a falling edge; one call covers one rising edge.
    task automatic cycle();
        #1;
        check_outputs();
        @(posedge clk);
        model_step();
        @(negedge clk);
        zero_inputs();
    endtask

    // Walks one instruction IF->WB with one idle cycle in MEM; kill reports mem_kill_o there.
    task automatic advance(input logic [31:0] pc, input bit adel, input bit bd, input bit ri,
                           input bit sys, input bit brk, input bit ov, input bit madel,
                           input bit mades, output bit kill);
        ifid_go = 1; if_pc = pc; if_adel = adel; cycle();
        idexe_go = 1; id_bd = bd; id_ri = ri; id_sys = sys; id_brk = brk; cycle();
        exemem_go = 1; exe_ov = ov; cycle();
        #1 kill = mem_kill_o;
        cycle();
        memwb_go = 1; mem_adel = madel; mem_ades = mades; mem_addr = pc + 32'h1000; cycle();
        #1;
    endtask

    bit kill;

    initial begin
        zero_inputs();
        m_id = empty_slot(); m_exe = empty_slot(); m_mem = empty_slot(); m_wb = empty_slot();
        resetn = 0;
        @(negedge clk);
        cycle();
        resetn = 0; cycle();
        resetn = 1;
        check("rst_valid", ex_valid_o, 0);
        check("rst_pc", ex_pc_o, 0);
        check("rst_kill", mem_kill_o, 0);

        advance(32'h100, 0, 0, 0, 0, 0, 0, 0, 0, kill);
        check("clean_valid", ex_valid_o, 0);
        check("clean_kill_mem", kill, 0);
        check("clean_kill_wb", mem_kill_o, 0);
        wb_over = 1; cycle();

        advance(32'h102, 1, 0, 0, 0, 0, 0, 0, 0, kill);
        check("adel_valid", ex_valid_o, 1);
        check("adel_code", ex_code_o, 5'h04);
        check("adel_pc", ex_pc_o, 32'h102);
        check("adel_bva", badvaddr_o, 32'h102);
        check("adel_bvv", badvaddr_valid_o, 1);
        wb_over = 1; cycle();

        advance(32'h204, 0, 1, 0, 1, 0, 0, 0, 0, kill);
        check("sys_code", ex_code_o, 5'h08);
        check("sys_bd", ex_bd_o, 1);
        check("sys_pc", ex_pc_o, 32'h200);
        check("sys_bvv", badvaddr_valid_o, 0);
        wb_over = 1; cycle();

        advance(32'h280, 0, 0, 1, 0, 0, 1, 0, 1, kill);
        check("ri_code", ex_code_o, 5'h0a);
        check("ri_kill_mem", kill, 1);
        check("ri_bvv", badvaddr_valid_o, 0);
        wb_over = 1; cycle();

        advance(32'h2c0, 0, 0, 0, 0, 0, 0, 1, 1, kill);
        check("madel_code", ex_code_o, 5'h04);
        check("madel_bva", badvaddr_o, 32'h12c0);
        wb_over = 1; cycle();

        // Cancel beats memwb_go on the same edge.
        ifid_go = 1; if_pc = 32'h300; cycle();
        idexe_go = 1; cycle();
        exemem_go = 1; exe_ov = 1; cycle();
        #1 check("cxl_kill_before", mem_kill_o, 1);
        memwb_go = 1; cancel = 1; cycle();
        #1 check("cxl_valid", ex_valid_o, 0);
        check("cxl_kill_after", mem_kill_o, 0);
        memwb_go = 1; cycle();
        #1 check("cxl_never_wb", ex_valid_o, 0);

        // Stall with the tag in EXE, then drain it alone.
        ifid_go = 1; if_pc = 32'h400; cycle();
        idexe_go = 1; id_ri = 1; cycle();
        for (int i = 0; i < 5; i++) cycle();
        exemem_go = 1; cycle();
        #1 check("stall_mem_tag", mem_kill_o, 1);
        memwb_go = 1; cycle();
        #1 check("stall_wb_code", ex_code_o, 5'h0a);
        check("stall_wb_pc", ex_pc_o, 32'h400);
        exemem_go = 1; cycle();
        memwb_go = 1; wb_over = 1; cycle();
        #1 check("stall_exe_empty", ex_valid_o, 0);

        for (int i = 0; i < 400; i++) begin
            ifid_go   = ($urandom_range(0, 1) == 1);
            idexe_go  = ($urandom_range(0, 1) == 1);
            exemem_go = ($urandom_range(0, 1) == 1);
            memwb_go  = ($urandom_range(0, 1) == 1);
            wb_over   = ($urandom_range(0, 1) == 1);
            cancel    = ($urandom_range(0, 31) == 0);
            if_pc     = $urandom & 32'hffff_fffc | 32'($urandom_range(0, 3));
            if_adel   = ($urandom_range(0, 7) == 0);
            id_bd     = ($urandom_range(0, 3) == 0);
            id_ri     = ($urandom_range(0, 7) == 0);
            id_sys    = ($urandom_range(0, 7) == 0);
            id_brk    = ($urandom_range(0, 7) == 0);
            exe_ov    = ($urandom_range(0, 7) == 0);
            mem_adel  = ($urandom_range(0, 9) == 0);
            mem_ades  = ($urandom_range(0, 9) == 0);
            mem_addr  = $urandom;
            c0_int    = ($urandom_range(0, 9) == 0);
            cycle();
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
